// File: rtl/instr_ram_loader.sv
// Writable instruction store: assembles a checksummed byte stream into 16-bit
// words, holds the core in reset until a verified program is present.
module instr_ram_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [15:0] HALT_WORD = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    input  logic [7:0]  pc,
    output logic [15:0] ir,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [7:0]  load_count
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      state_r, state_nx_s;
    logic [7:0]  len_r, len_nx_s;
    logic [7:0]  hi_r, hi_nx_s;
    logic [7:0]  chk_r, chk_nx_s;
    logic [7:0]  addr_r, addr_nx_s;
    logic [7:0]  count_nx_s;
    logic        we_s;
    logic        accept_s;
    logic [15:0] mem_r [DEPTH];

    assign accept_s = rx_valid && rx_ready;

    // Next-state and datapath decode for the load sequence
    always_comb begin
        state_nx_s = state_r;
        len_nx_s   = len_r;
        hi_nx_s    = hi_r;
        chk_nx_s   = chk_r;
        addr_nx_s  = addr_r;
        count_nx_s = load_count;
        we_s       = 1'b0;
        case (state_r)
            S_LEN: begin
                if (accept_s) begin
                    if ((rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH_W)) begin
                        state_nx_s = S_ERR;
                    end else begin
                        len_nx_s   = rx_data;
                        chk_nx_s   = rx_data;
                        addr_nx_s  = 8'd0;
                        state_nx_s = S_HI;
                    end
                end else begin
                    state_nx_s = S_LEN;
                end
            end
            S_HI: begin
                if (accept_s) begin
                    hi_nx_s    = rx_data;
                    chk_nx_s   = chk_update(chk_r, rx_data);
                    state_nx_s = S_LO;
                end else begin
                    state_nx_s = S_HI;
                end
            end
            S_LO: begin
                if (accept_s) begin
                    we_s       = 1'b1;
                    chk_nx_s   = chk_update(chk_r, rx_data);
                    addr_nx_s  = addr_r + 8'd1;
                    count_nx_s = load_count + 8'd1;
                    if ((addr_r + 8'd1) == len_r) begin
                        state_nx_s = S_CHK;
                    end else begin
                        state_nx_s = S_HI;
                    end
                end else begin
                    state_nx_s = S_LO;
                end
            end
            S_CHK: begin
                if (accept_s) begin
                    if (rx_data == chk_r) begin
                        state_nx_s = S_DONE;
                    end else begin
                        state_nx_s = S_ERR;
                    end
                end else begin
                    state_nx_s = S_CHK;
                end
            end
            S_DONE, S_ERR: begin
                // Memory is deliberately left intact across a reload
                if (reload) begin
                    state_nx_s = S_LEN;
                    chk_nx_s   = 8'd0;
                    count_nx_s = 8'd0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = S_LEN;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_LEN;
            len_r      <= 8'd0;
            hi_r       <= 8'd0;
            chk_r      <= 8'd0;
            addr_r     <= 8'd0;
            load_count <= 8'd0;
            rx_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            len_r      <= len_nx_s;
            hi_r       <= hi_nx_s;
            chk_r      <= chk_nx_s;
            addr_r     <= addr_nx_s;
            load_count <= count_nx_s;
            rx_ready   <= (state_nx_s == S_LEN) || (state_nx_s == S_HI) ||
                          (state_nx_s == S_LO)  || (state_nx_s == S_CHK);
            cpu_hold   <= (state_nx_s != S_DONE);
            done       <= (state_nx_s == S_DONE);
            err        <= (state_nx_s == S_ERR);
        end
    end

    // Instruction memory, refilled with the halt opcode on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= HALT_WORD;
            end
        end else if (we_s) begin
            mem_r[addr_r[AW-1:0]] <= {hi_r, rx_data};
        end
    end

    assign ir = ({1'b0, pc} < DEPTH_W) ? mem_r[pc[AW-1:0]] : HALT_WORD;

endmodule

// File: tb/tb_instr_ram_loader.sv
// Directed self-checking bench for instr_ram_loader: table-driven read checks
// plus hand-written load, error, gap, reload and mid-load reset sequences.
module tb_instr_ram_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [7:0]  load_count;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
    } rd_vec_t;

    rd_vec_t    good_tbl [6];
    logic [7:0] good_s   [6];
    logic [7:0] big_hi   [32];
    logic [7:0] big_lo   [32];

    instr_ram_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .pc         (pc),
        .ir         (ir),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        check("rx_ready_before_byte", {15'd0, rx_ready}, 16'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input logic [7:0] lc);
        check({tag, "_done"},     {15'd0, done},       {15'd0, d});
        check({tag, "_err"},      {15'd0, err},        {15'd0, e});
        check({tag, "_cpu_hold"}, {15'd0, cpu_hold},   {15'd0, h});
        check({tag, "_count"},    {8'd0, load_count},  {8'd0, lc});
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
        pc = a;
        #1;
        check(tag, ir, exp);
    endtask

    initial begin
        logic [7:0] chk;
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        pc       = 8'd0;

        good_s = '{8'h02, 8'h20, 8'h00, 8'h20, 8'h11, 8'h13};
        good_tbl[0] = '{8'd0,   16'h2000};
        good_tbl[1] = '{8'd1,   16'h2011};
        good_tbl[2] = '{8'd2,   16'hF000};
        good_tbl[3] = '{8'd31,  16'hF000};
        good_tbl[4] = '{8'd32,  16'hF000};
        good_tbl[5] = '{8'd255, 16'hF000};

        #12;
        // Reset state, sampled while reset is still asserted
        check_status("reset", 1'b0, 1'b0, 1'b1, 8'd0);
        check("reset_rx_ready", {15'd0, rx_ready}, 16'd1);
        read_check("reset_ir0", 8'd0, 16'hF000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Good load, continuous valid
        for (int i = 0; i < 6; i++) send(good_s[i], 0);
        check_status("good", 1'b1, 1'b0, 1'b0, 8'd2);
        check("good_rx_ready", {15'd0, rx_ready}, 16'd0);
        for (int i = 0; i < 6; i++) read_check("good_ir", good_tbl[i].pc, good_tbl[i].ir);

        // A byte offered in DONE must not be accepted
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check_status("done_hold", 1'b1, 1'b0, 1'b0, 8'd2);

        // Reload and a one-word program
        pulse_reload();
        check_status("reload", 1'b0, 1'b0, 1'b1, 8'd0);
        check("reload_rx_ready", {15'd0, rx_ready}, 16'd1);
        send(8'h01, 0); send(8'hF0, 0); send(8'h00, 0); send(8'hF1, 0);
        check_status("reload_load", 1'b1, 1'b0, 1'b0, 8'd1);
        read_check("reload_ir0", 8'd0, 16'hF000);
        read_check("reload_ir1", 8'd1, 16'h2011);

        // Bad checksum
        do_reset();
        for (int i = 0; i < 5; i++) send(good_s[i], 0);
        send(8'h55, 0);
        check_status("badchk", 1'b0, 1'b1, 1'b1, 8'd2);
        read_check("badchk_ir0", 8'd0, 16'h2000);

        // Bad length 0
        do_reset();
        send(8'h00, 0);
        check_status("len0", 1'b0, 1'b1, 1'b1, 8'd0);
        check("len0_rx_ready", {15'd0, rx_ready}, 16'd0);

        // Bad length 33
        do_reset();
        send(8'h21, 0);
        check_status("len33", 1'b0, 1'b1, 1'b1, 8'd0);

        // Full-depth load of 32 words
        do_reset();
        chk = 8'h20;
        for (int i = 0; i < 32; i++) begin
            big_hi[i] = 8'h40 + 8'(i);
            big_lo[i] = 8'(i * 3);
            chk = chk ^ big_hi[i] ^ big_lo[i];
        end
        send(8'h20, 0);
        for (int i = 0; i < 32; i++) begin
            send(big_hi[i], 0);
            send(big_lo[i], 0);
        end
        send(chk, 0);
        check_status("full", 1'b1, 1'b0, 1'b0, 8'd32);
        read_check("full_ir0",  8'd0,  {8'h40, 8'h00});
        read_check("full_ir17", 8'd17, {8'h51, 8'd51});
        read_check("full_ir31", 8'd31, {8'h5F, 8'd93});
        read_check("full_ir32", 8'd32, 16'hF000);

        // Good load with three idle cycles between bytes
        do_reset();
        for (int i = 0; i < 3; i++) send(good_s[i], 3);
        check("gap_mid_count", {8'd0, load_count}, 16'd1);
        check("gap_mid_done", {15'd0, done}, 16'd0);
        read_check("gap_mid_ir0", 8'd0, 16'h2000);
        // reload outside DONE/ERR is ignored
        pulse_reload();
        for (int i = 3; i < 6; i++) send(good_s[i], 3);
        check_status("gap", 1'b1, 1'b0, 1'b0, 8'd2);
        for (int i = 0; i < 6; i++) read_check("gap_ir", good_tbl[i].pc, good_tbl[i].ir);

        // Reset in the middle of a load
        do_reset();
        send(8'h02, 0); send(8'h20, 0); send(8'h00, 0);
        reset = 1'b1;
        #1;
        check_status("midrst", 1'b0, 1'b0, 1'b1, 8'd0);
        check("midrst_rx_ready", {15'd0, rx_ready}, 16'd1);
        for (int a = 0; a < 256; a++) read_check("midrst_ir", 8'(a), 16'hF000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) send(good_s[i], 0);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 8'd2);
        read_check("after_rst_ir1", 8'd1, 16'h2011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
